// File: rtl/uart_frame_core.sv
// uart_frame_core: parametrised full-duplex UART with configurable width, parity and
// stop bits. The receiver synchronises rx, samples mid-bit, rejects short start glitches
// and reports sticky parity, framing and overrun flags alongside ready.
module uart_frame_core #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned     CntW      = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CntW-1:0] CntLast   = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] CntHalf   = CntW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [3:0]      DataLast  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast  = 4'(STOP_BITS - 1);
  localparam bit              HasParity = (PARITY != 0);
  localparam bit              OddParity = (PARITY == 2);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
  } rx_state_e;

  // ---------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;

  // TX next state: tx is registered and changes on the first edge of each bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    if (tx_state_q == TxIdle) begin
      if (data_en) begin
        tx_state_d = TxStart;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_shift_d = data_in;
        tx_par_d   = (^data_in) ^ OddParity;
        tx_d       = 1'b0;
        tx_busy_d  = 1'b1;
      end
    end else if (tx_cnt_q != CntLast) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TxStart: begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
        TxData: begin
          if (tx_bit_q == DataLast) begin
            if (HasParity) begin
              tx_state_d = TxParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              tx_bit_d   = '0;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_d       = tx_shift_q[1];
          end
        end
        TxParity: begin
          tx_state_d = TxStop;
          tx_bit_d   = '0;
          tx_d       = 1'b1;
        end
        TxStop: begin
          if (tx_bit_q == StopLast) begin
            tx_state_d = TxIdle;
            tx_busy_d  = 1'b0;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  // TX state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // ---------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  // Two-stage synchroniser; both stages idle high so reset does not fake a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 ready_q, ready_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 par_mismatch;

  assign par_mismatch = HasParity && (((^rx_shift_q) ^ rx_par_q) != OddParity);

  // RX next state; a completing frame overrides a simultaneous ready_clr.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    if (ready_clr) begin
      ready_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    case (rx_state_q)
      RxIdle: begin
        if (!rx_s_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_state_d = HasParity ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxParity: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s_q;
          rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          data_out_d = rx_shift_q;
          ready_d    = 1'b1;
          perr_d     = perr_d | par_mismatch;
          ferr_d     = ferr_d | !rx_s_q;
          ovr_d      = ovr_d | (ready_q & !ready_clr);
          // A low stop sample may be a break; wait for the line to recover first.
          rx_state_d = rx_s_q ? RxIdle : RxWaitHigh;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        if (rx_s_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX state and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ready      = ready_q;
  assign data_out   = data_out_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_frame_core.sv
// Scoreboard bench for uart_frame_core. Two instances: A (CPP=4, 8 data, even parity,
// 1 stop) and B (CPP=8, 5 data, odd parity, 2 stop). Stimulus pushes expected frames,
// a monitor pops them whenever ready rises.
module tb_uart_frame_core;

  localparam int unsigned ACpp = 4, ADb = 8, APar = 1, AStop = 1;
  localparam int unsigned BCpp = 8, BDb = 5, BPar = 2, BStop = 2;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
    logic        ovr;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned last_e0_a = 0;
  int unsigned last_e0_b = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  logic [ADb-1:0] a_data_in = '0;
  logic [ADb-1:0] a_data_out;
  logic a_data_en = 1'b0, a_loop = 1'b1, a_ext = 1'b1, a_auto = 1'b1;
  logic a_clr_mon = 1'b0, a_clr_man = 1'b0;
  logic a_tx, a_busy, a_rx, a_ready, a_clr, a_perr, a_ferr, a_ovr;

  logic [BDb-1:0] b_data_in = '0;
  logic [BDb-1:0] b_data_out;
  logic b_data_en = 1'b0, b_loop = 1'b1, b_ext = 1'b1, b_auto = 1'b1;
  logic b_clr_mon = 1'b0, b_clr_man = 1'b0;
  logic b_tx, b_busy, b_rx, b_ready, b_clr, b_perr, b_ferr, b_ovr;

  assign a_rx  = a_loop ? a_tx : a_ext;
  assign a_clr = a_clr_mon | a_clr_man;
  assign b_rx  = b_loop ? b_tx : b_ext;
  assign b_clr = b_clr_mon | b_clr_man;

  uart_frame_core #(
    .CLOCKS_PER_PULSE(ACpp), .DATA_BITS(ADb), .PARITY(APar), .STOP_BITS(AStop)
  ) u_dut_a (
    .clk(clk), .rst(rst), .data_in(a_data_in), .data_en(a_data_en), .tx(a_tx),
    .tx_busy(a_busy), .rx(a_rx), .ready(a_ready), .ready_clr(a_clr),
    .data_out(a_data_out), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr)
  );

  uart_frame_core #(
    .CLOCKS_PER_PULSE(BCpp), .DATA_BITS(BDb), .PARITY(BPar), .STOP_BITS(BStop)
  ) u_dut_b (
    .clk(clk), .rst(rst), .data_in(b_data_in), .data_en(b_data_en), .tx(b_tx),
    .tx_busy(b_busy), .rx(b_rx), .ready(b_ready), .ready_clr(b_clr),
    .data_out(b_data_out), .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int unsigned cpp_of(input bit s); return s ? BCpp : ACpp; endfunction
  function automatic int unsigned db_of(input bit s);  return s ? BDb : ADb;   endfunction
  function automatic int unsigned par_of(input bit s); return s ? BPar : APar; endfunction
  function automatic int unsigned stp_of(input bit s); return s ? BStop : AStop; endfunction
  function automatic int unsigned pbits(input bit s); return (par_of(s) != 0) ? 1 : 0; endfunction

  function automatic int unsigned flen(input bit s);
    return 1 + db_of(s) + pbits(s) + stp_of(s);
  endfunction

  // Cycles from first low line edge to ready: sync + detect + half bit + full bits to stop.
  function automatic int unsigned rx_lat(input bit s);
    return 3 + cpp_of(s) / 2 + (1 + db_of(s) + pbits(s)) * cpp_of(s);
  endfunction

  function automatic logic par_bit(input bit s, input logic [31:0] d);
    int unsigned ones;
    ones = $countones(d);
    if (par_of(s) == 1) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic logic frame_bit(input bit s, input logic [31:0] d, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= db_of(s)) return d[k-1];
    if (pbits(s) == 1 && k == db_of(s) + 1) return par_bit(s, d);
    return 1'b1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit s, input logic [31:0] d, input logic pe, input logic fe,
                          input int unsigned due);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.ovr = 1'b0; e.due = due;
    if (s) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic score(input bit s);
    exp_t e;
    logic [31:0] dout;
    dout = s ? 32'(b_data_out) : 32'(a_data_out);
    if ((s ? q_b.size() : q_a.size()) == 0) begin
      check(s ? "b_spurious_ready" : "a_spurious_ready", 32'd1, 32'd0);
      return;
    end
    if (s) e = q_b.pop_front();
    else e = q_a.pop_front();
    check(s ? "b_data_out" : "a_data_out", dout, e.data);
    check(s ? "b_parity_err" : "a_parity_err", 32'(s ? b_perr : a_perr), 32'(e.perr));
    check(s ? "b_frame_err" : "a_frame_err", 32'(s ? b_ferr : a_ferr), 32'(e.ferr));
    check(s ? "b_overrun" : "a_overrun", 32'(s ? b_ovr : a_ovr), 32'(e.ovr));
    check(s ? "b_rx_latency" : "a_rx_latency", cyc, e.due);
  endtask

  // Monitor: pops the scoreboard on each rising ready, optionally clears it next edge.
  initial begin : monitor
    logic pa, pb;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      a_clr_mon = 1'b0;
      b_clr_mon = 1'b0;
      if (!rst) begin
        if (a_ready === 1'b1 && !pa) begin score(1'b0); a_clr_mon = a_auto; end
        if (b_ready === 1'b1 && !pb) begin score(1'b1); b_clr_mon = b_auto; end
      end
      pa = a_ready;
      pb = b_ready;
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic settle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cycle(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input bit s);
    for (int i = 0; i < 2000; i++) begin
      if (!(s ? b_busy : a_busy)) return;
      @(negedge clk);
    end
    check(s ? "b_idle_timeout" : "a_idle_timeout", 32'd1, 32'd0);
  endtask

  // Loopback frame: checks tx every cycle and the exact tx_busy window.
  task automatic send(input bit s, input logic [31:0] d, input bit push);
    int unsigned e0, span;
    wait_idle(s);
    span = flen(s) * cpp_of(s);
    if (s) begin b_data_in = d[BDb-1:0]; b_data_en = 1'b1; end
    else begin a_data_in = d[ADb-1:0]; a_data_en = 1'b1; end
    e0 = cyc + 1;
    if (s) last_e0_b = e0;
    else last_e0_a = e0;
    if (push) push_exp(s, d, 1'b0, 1'b0, e0 + rx_lat(s));
    @(negedge clk);
    if (s) begin b_data_en = 1'b0; b_data_in = BDb'($urandom); end
    else begin a_data_en = 1'b0; a_data_in = ADb'($urandom); end
    for (int t = 0; t < int'(span); t++) begin
      check(s ? "b_tx_bit" : "a_tx_bit", 32'(s ? b_tx : a_tx),
            32'(frame_bit(s, d, t / cpp_of(s))));
      check(s ? "b_tx_busy" : "a_tx_busy", 32'(s ? b_busy : a_busy), 32'd1);
      @(negedge clk);
    end
    check(s ? "b_busy_fall" : "a_busy_fall", 32'(s ? b_busy : a_busy), 32'd0);
    check(s ? "b_tx_idle" : "a_tx_idle", 32'(s ? b_tx : a_tx), 32'd1);
  endtask

  // External frame on rx with chosen parity bit and first stop bit, then one idle bit.
  task automatic drive(input bit s, input logic [31:0] d, input logic p, input logic stp);
    logic bitv;
    if (s) b_loop = 1'b0;
    else a_loop = 1'b0;
    push_exp(s, d, (pbits(s) == 1) && (p != par_bit(s, d)), !stp, cyc + rx_lat(s));
    for (int k = 0; k < int'(flen(s)); k++) begin
      bitv = frame_bit(s, d, k);
      if (pbits(s) == 1 && k == int'(db_of(s)) + 1) bitv = p;
      if (k == int'(db_of(s) + pbits(s)) + 1) bitv = stp;
      if (s) b_ext = bitv;
      else a_ext = bitv;
      settle(cpp_of(s));
    end
    if (s) b_ext = 1'b1;
    else a_ext = 1'b1;
    settle(cpp_of(s));
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [31:0] d;
    settle(3);
    check("a_reset_tx", 32'(a_tx), 32'd1);
    check("a_reset_busy", 32'(a_busy), 32'd0);
    check("a_reset_ready", 32'(a_ready), 32'd0);
    check("a_reset_data", 32'(a_data_out), 32'd0);
    check("a_reset_flags", {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
    check("b_reset_tx", 32'(b_tx), 32'd1);
    check("b_reset_busy", 32'(b_busy), 32'd0);
    check("b_reset_ready", 32'(b_ready), 32'd0);
    check("b_reset_flags", {29'd0, b_perr, b_ferr, b_ovr}, 32'd0);
    rst = 1'b0;
    settle(2);

    // Loopback sweep and random back-to-back frames.
    for (int i = 0; i < 256; i++) send(1'b0, 32'(i), 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 32'($urandom_range(0, 255)), 1'b1);
      settle($urandom_range(0, 4));
    end
    settle(8);

    // Parity: good and bad parity bit on 0xA5, then flags must be clear.
    drive(1'b0, 32'hA5, 1'b0, 1'b1);
    drive(1'b0, 32'hA5, 1'b1, 1'b1);
    settle(4);
    check("a_clr_ready", 32'(a_ready), 32'd0);
    check("a_clr_flags", {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);

    // Framing error, then a held-low break spanning three frames.
    drive(1'b0, 32'h3C, par_bit(1'b0, 32'h3C), 1'b0);
    push_exp(1'b0, 32'h0, par_bit(1'b0, 32'h0), 1'b1, cyc + rx_lat(1'b0));
    a_ext = 1'b0;
    settle(3 * flen(1'b0) * ACpp);
    a_ext = 1'b1;
    settle(20);
    check("a_break_ready_cleared", 32'(a_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      d = 32'($urandom_range(0, 255));
      drive(1'b0, d, logic'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      settle($urandom_range(1, 4));
    end
    a_loop = 1'b1;
    settle(8);

    // Overrun: two frames without clearing.
    a_auto = 1'b0;
    send(1'b0, 32'h11, 1'b1);
    send(1'b0, 32'h22, 1'b0);
    wait_cycle(last_e0_a + rx_lat(1'b0));
    check("a_ovr_ready", 32'(a_ready), 32'd1);
    check("a_ovr_data", 32'(a_data_out), 32'h22);
    check("a_ovr_flag", 32'(a_ovr), 32'd1);
    a_clr_man = 1'b1;
    @(negedge clk);
    a_clr_man = 1'b0;
    check("a_lone_clr_ready", 32'(a_ready), 32'd0);
    check("a_lone_clr_ovr", 32'(a_ovr), 32'd0);

    // Collision: ready_clr on the completion edge of a frame arriving over a full ready.
    send(1'b0, 32'h33, 1'b1);
    send(1'b0, 32'h44, 1'b0);
    wait_cycle(last_e0_a + rx_lat(1'b0) - 1);
    a_clr_man = 1'b1;
    @(negedge clk);
    a_clr_man = 1'b0;
    check("a_coll_ready", 32'(a_ready), 32'd1);
    check("a_coll_data", 32'(a_data_out), 32'h44);
    check("a_coll_ovr", 32'(a_ovr), 32'd0);
    a_clr_man = 1'b1;
    @(negedge clk);
    a_clr_man = 1'b0;
    a_auto = 1'b1;
    settle(4);

    // Instance B: start glitch, then loopback sweep, random frames and parity errors.
    b_loop = 1'b0;
    b_ext = 1'b0;
    settle(2);
    b_ext = 1'b1;
    settle(40);
    check("b_glitch_no_ready", 32'(b_ready), 32'd0);
    b_loop = 1'b1;
    for (int i = 0; i < 32; i++) send(1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, 32'($urandom_range(0, 31)), 1'b1);
    settle(16);
    drive(1'b1, 32'h15, !par_bit(1'b1, 32'h15), 1'b1);
    d = 32'($urandom_range(0, 31));
    drive(1'b1, d, par_bit(1'b1, d), 1'b1);
    b_loop = 1'b1;
    settle(16);

    // Reset in the middle of bit 4 of a TX frame.
    wait_idle(1'b0);
    a_data_in = 8'h5A;
    a_data_en = 1'b1;
    @(negedge clk);
    a_data_en = 1'b0;
    settle(4 * ACpp + 1);
    rst = 1'b1;
    @(negedge clk);
    check("a_midrst_tx", 32'(a_tx), 32'd1);
    check("a_midrst_busy", 32'(a_busy), 32'd0);
    check("a_midrst_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    settle(2);
    send(1'b0, 32'($urandom_range(0, 255)), 1'b1);

    // Drain outstanding expectations.
    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_core.md
# uart_frame_core

Parametrised full-duplex UART core: the next generation of the team's fixed-format UART. It adds configurable data width, parity and stop-bit count, plus a receiver with input synchronisation, mid-bit sampling, glitch rejection and error/overrun reporting. It sits between the board-level UART pins and the user logic, keeping the existing `data_en` / `ready` / `ready_clr` handshake so current loopback benches port directly.

## Interface

- `CLOCKS_PER_PULSE`, default 4: clock cycles per bit. Legal values are even and ≥4.
- `DATA_BITS`, default 8: payload bits per frame, 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_BITS  TX payload, sampled only on the frame-start edge.
- `data_en`  in  1  level request; a frame starts on any edge where TX is idle and `data_en`=1.
- `tx`  out  1  serial output, idles high.
- `tx_busy`  out  1  high while a TX frame is in progress.
- `rx`  in  1  asynchronous serial input.
- `ready`  out  1  a received frame is available.
- `ready_clr`  in  1  clears `ready`, `parity_err`, `frame_err` and `overrun`.
- `data_out`  out  DATA_BITS  last received payload.
- `parity_err`, `frame_err`, `overrun`  out  1 each  sticky flags, valid with `ready`.

## Operation

- **Frame format:** start(0), data LSB first, parity bit (if `PARITY`≠0), stop(1) × `STOP_BITS`. Frame length F = 1 + DATA_BITS + P + STOP_BITS, where P = (PARITY≠0).
- **Reset values:** `tx`=1, `tx_busy`=0, `ready`=0, `data_out`=0, all flags 0, both RX synchroniser stages = 1. Both FSMs go to IDLE. `rst` mid-frame abandons the frame; no flag is set.
- **TX FSM states:** IDLE → START → DATA → PARITY (skipped if P=0) → STOP → IDLE.
  - Even parity makes the total count of 1s in data+parity even; odd parity makes it odd.
  - `data_in` changes during a frame have no effect on that frame.
- **RX path:** `rx` passes through a 2-FF synchroniser to give `rx_s`.
- **RX FSM states:** IDLE → START → DATA → PARITY (if P) → STOP → IDLE, plus a WAIT_HIGH state.
  - IDLE: moves to START on the first edge where `rx_s`=0, with the bit counter cleared.
  - START: re-checks `rx_s` after CLOCKS_PER_PULSE/2 cycles. If `rx_s`=1 the start is a glitch: return to IDLE with no flags set. Otherwise proceed.
  - Subsequent samples are taken every CLOCKS_PER_PULSE cycles (mid-bit).
  - Only the first stop bit is checked.
- **At the stop sample edge, all of the following happen on that edge:**
  - `data_out` ← assembled payload.
  - `ready` ← 1.
  - `parity_err` |= parity mismatch.
  - `frame_err` |= (stop sample = 0).
  - `overrun` |= (`ready` was already 1 and `ready_clr`=0).
  - `data_out` is always overwritten.
- **Break handling:** if the stop sample is 0, enter WAIT_HIGH and return to IDLE only after `rx_s`=1. A held-low line therefore yields exactly one frame with `frame_err`=1 and `data_out`=0.
- **Simultaneous `ready_clr` and frame completion:** completion wins. `ready`=1, the flags reflect only the new frame, and `overrun` is not set.
- **Independence:** TX and RX run fully concurrently.
- **Post-reset line state:** if `rx` is low when `rst` deasserts, this is treated as a start bit.

## Timing

- **TX start:** let E0 be the edge where TX is idle and `data_en`=1. At E0: `tx`←0, `tx_busy`←1, `data_in` latched.
- **TX bit timing:** bit k (start = 0) drives `tx` during edges E0+k·CPP .. E0+(k+1)·CPP−1.
- **TX end:** `tx_busy` falls at edge E0+F·CPP. The earliest next start is E0+F·CPP+1, giving one idle cycle minimum between back-to-back frames when `data_en` is held.
- **RX latency:** with `tx` looped to `rx`, `ready` rises at edge E0 + 3 + CPP/2 + (1+DATA_BITS+P)·CPP.
  - Breakdown: 2 cycles of synchroniser, 1 cycle of IDLE detection.
  - Example: CPP=4, 8N1 gives E0+41.
- **Glitch rejection:** a low pulse on `rx` shorter than CPP/2−1 cycles never produces `ready`.
- **`ready_clr` effect:** acts on the next edge. `ready` is low the cycle after a lone `ready_clr`.

## Test plan

1. **Loopback sweep:** CPP=4, 8N1, `ready_clr` pulsed after each frame, `data_in` 0x00..0xFF. Required: every `data_out` matches, all flags 0, `ready` rises exactly 41 cycles after `tx` falls.
2. **Parity error:** PARITY=1, external driver sends 0xA5. Correct parity bit is 0 → `ready`, `parity_err`=0. Same frame with parity bit 1 → `data_out`=0xA5, `parity_err`=1. Then `ready_clr` → all flags 0.
3. **Framing and break:** stop bit forced 0 on 0x3C → `frame_err`=1, `data_out`=0x3C. `rx` held low for 3 frames → exactly one `ready`, with `data_out`=0x00 and `frame_err`=1. No further `ready` until `rx` returns high.
4. **Overrun and collision:** two frames (0x11, 0x22) with no `ready_clr` → `overrun`=1, `data_out`=0x22. Repeat with `ready_clr` asserted on the completion edge → `ready`=1, `overrun`=0.
5. **Glitch and width corners:** CPP=8, 2-cycle low pulse → no `ready`, RX back in IDLE. DATA_BITS=5, PARITY=2, STOP_BITS=2, loopback 0x00..0x1F → all match; `tx_busy` high for exactly 9·8 cycles per frame.
6. **Reset mid-frame:** `rst` for one cycle at bit 4 of a TX frame. Next edge: `tx`=1, `tx_busy`=0, `ready`=0. The next `data_en` frame transmits and receives correctly.
